// File: rtl/axis_pulse_meta_reader_pkg.sv
// Shared constants for the pulse metadata reader: UART frame layout and
// the frame-size helpers used by the top level and the serializer.
package axis_pulse_meta_reader_pkg;

    localparam int UART_BITS_PER_BYTE = 11;
    localparam int UART_DATA_BITS     = 7;
    localparam int UART_START_OFS     = 0;
    localparam int UART_DATA_OFS      = 1;
    localparam int UART_FLAG_OFS      = 8;
    localparam int UART_STOP_OFS      = 9;
    localparam int UART_PAD_OFS       = 10;

    // Number of 7-bit data slices needed to carry a counter of cnt_width bits
    function automatic int uart_num_bytes(input int cnt_width);
        return (cnt_width + UART_DATA_BITS - 1) / UART_DATA_BITS;
    endfunction

    // Total serial bits in one frame
    function automatic int uart_frame_bits(input int cnt_width);
        return uart_num_bytes(cnt_width) * UART_BITS_PER_BYTE;
    endfunction

endpackage

// File: rtl/axis_pulse_meta_uart_tx.sv
// Framed UART serializer. A load captures the whole frame into a shift
// register; the line then advances one bit every (prescale+1) handshakes.
// The prescale value is captured at load so mid-frame changes are ignored.
module axis_pulse_meta_uart_tx
    import axis_pulse_meta_reader_pkg::*;
#(
    parameter int DATA_WIDTH     = 40,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      load,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      hs,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      line,
    output logic                      busy
);

    localparam int NUM_BYTES  = uart_num_bytes(DATA_WIDTH);
    localparam int FRAME_BITS = uart_frame_bits(DATA_WIDTH);
    localparam int PAD_WIDTH  = NUM_BYTES * UART_DATA_BITS;
    localparam int IDX_WIDTH  = $clog2(FRAME_BITS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(FRAME_BITS - 1);

    // Lay out start/data/flag/stop/pad for every byte, LSB first
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_WIDTH-1:0] value);
        logic [FRAME_BITS-1:0] frame;
        logic [PAD_WIDTH-1:0]  padded;
        padded = PAD_WIDTH'(value);
        frame  = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            frame[b*UART_BITS_PER_BYTE + UART_START_OFS] = 1'b0;
            for (int d = 0; d < UART_DATA_BITS; d++) begin
                frame[b*UART_BITS_PER_BYTE + UART_DATA_OFS + d] = padded[b*UART_DATA_BITS + d];
            end
            frame[b*UART_BITS_PER_BYTE + UART_FLAG_OFS] = (b == 0) ? 1'b1 : 1'b0;
            frame[b*UART_BITS_PER_BYTE + UART_STOP_OFS] = 1'b1;
            frame[b*UART_BITS_PER_BYTE + UART_PAD_OFS]  = 1'b1;
        end
        return frame;
    endfunction

    logic [FRAME_BITS-1:0]     shift_r;
    logic [IDX_WIDTH-1:0]      idx_r;
    logic [PRESCALE_WIDTH-1:0] presc_cnt_r;
    logic [PRESCALE_WIDTH-1:0] presc_max_r;
    logic                      busy_r;
    logic                      line_r;
    logic [FRAME_BITS-1:0]     frame_s;

    assign frame_s = build_frame(data);

    // Serializer: load has priority, otherwise one prescaler tick per handshake while busy
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            shift_r     <= '1;
            idx_r       <= '0;
            presc_cnt_r <= '0;
            presc_max_r <= '0;
            busy_r      <= 1'b0;
            line_r      <= 1'b1;
        end else if (load) begin
            shift_r     <= frame_s;
            idx_r       <= '0;
            presc_cnt_r <= '0;
            presc_max_r <= prescale;
            busy_r      <= 1'b1;
            line_r      <= frame_s[0];
        end else if (hs && busy_r) begin
            if (presc_cnt_r == presc_max_r) begin
                presc_cnt_r <= '0;
                if (idx_r == LAST_IDX) begin
                    busy_r <= 1'b0;
                    line_r <= 1'b1;
                end else begin
                    idx_r   <= idx_r + IDX_WIDTH'(1);
                    shift_r <= {1'b1, shift_r[FRAME_BITS-1:1]};
                    line_r  <= shift_r[1];
                end
            end else begin
                presc_cnt_r <= presc_cnt_r + PRESCALE_WIDTH'(1);
            end
        end
    end

    assign line = line_r;
    assign busy = busy_r;

endmodule

// File: rtl/axis_pulse_meta_reader.sv
// AXI4-Stream pass-through that taps sample MSBs into misc_data, counts key
// pulses (MSB rising edges), reflects each count serially on misc_data[1]
// and sends every 2**DECIM_LOG2-th count as a framed UART stream.
module axis_pulse_meta_reader
    import axis_pulse_meta_reader_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 40,
    parameter int M_AXIS_TDATA_WIDTH = 32,
    parameter int MISC_WIDTH         = 8,
    parameter int CNT_WIDTH          = 40,
    parameter int DECIM_LOG2         = 4,
    parameter int PRESCALE_WIDTH     = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [PRESCALE_WIDTH-1:0]     cfg_prescale,
    input  logic                          cfg_truncate,
    output logic [MISC_WIDTH-1:0]         misc_data,
    output logic [CNT_WIDTH-1:0]          pulse_count,
    output logic                          uart_overrun,
    output logic                          s_axis_tready,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid
);

    localparam int POS_WIDTH = $clog2(CNT_WIDTH);
    localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(CNT_WIDTH - 1);

    logic                  enbl_r;
    logic                  key_latch_r;
    logic                  uart_overrun_r;
    logic [CNT_WIDTH-1:0]  pulse_count_r;
    logic [CNT_WIDTH-1:0]  reflect_buf_r;
    logic [POS_WIDTH-1:0]  reflect_pos_r;
    logic                  reflect_active_r;
    logic [MISC_WIDTH-1:0] misc_data_r;
    logic [MISC_WIDTH-1:0] misc_next_s;

    logic hs_s, key_s, key_edge_s, reflect_bit_s;
    logic uart_start_s, uart_load_s, uart_line_s, uart_busy_s;
    logic unused_tdata_s;

    assign s_axis_tready = enbl_r & m_axis_tready;
    assign m_axis_tvalid = enbl_r & s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata[M_AXIS_TDATA_WIDTH-1:0];

    assign hs_s          = s_axis_tvalid & s_axis_tready;
    assign key_s         = s_axis_tdata[S_AXIS_TDATA_WIDTH-1];
    assign key_edge_s    = hs_s & key_s & ~key_latch_r;
    assign reflect_bit_s = reflect_buf_r[reflect_pos_r];
    assign uart_start_s  = key_edge_s & (pulse_count_r[DECIM_LOG2-1:0] == {DECIM_LOG2{1'b0}});
    // A start while busy either restarts the frame or is dropped
    assign uart_load_s   = uart_start_s & (~uart_busy_s | cfg_truncate);
    assign unused_tdata_s = ^s_axis_tdata;

    // Stream enable rises on the first cycle out of reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            enbl_r <= 1'b0;
        end else begin
            enbl_r <= 1'b1;
        end
    end

    // Key edge tracking, pulse counter and sticky overrun; all advance on handshake only
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            key_latch_r    <= 1'b0;
            pulse_count_r  <= '0;
            uart_overrun_r <= 1'b0;
        end else begin
            if (hs_s) begin
                key_latch_r <= key_s;
            end
            if (key_edge_s) begin
                pulse_count_r <= pulse_count_r + CNT_WIDTH'(1);
            end
            if (uart_start_s && uart_busy_s) begin
                uart_overrun_r <= 1'b1;
            end
        end
    end

    // Reflect shifter: restart on edge, otherwise walk LSB-first to the top bit and park
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            reflect_buf_r    <= '0;
            reflect_pos_r    <= POS_LAST;
            reflect_active_r <= 1'b0;
        end else if (key_edge_s) begin
            reflect_buf_r    <= pulse_count_r;
            reflect_pos_r    <= '0;
            reflect_active_r <= 1'b1;
        end else if (hs_s) begin
            if (reflect_pos_r != POS_LAST) begin
                reflect_pos_r    <= reflect_pos_r + POS_WIDTH'(1);
                reflect_active_r <= ((reflect_pos_r + POS_WIDTH'(1)) != POS_LAST);
            end else begin
                reflect_active_r <= 1'b0;
            end
        end
    end

    // Tap word: sample MSBs above, pre-update serial state below
    always_comb begin
        misc_next_s    = '0;
        misc_next_s[0] = uart_line_s;
        misc_next_s[1] = reflect_bit_s;
        misc_next_s[2] = reflect_active_r;
        misc_next_s[3] = key_edge_s;
        for (int i = 4; i < MISC_WIDTH; i++) begin
            misc_next_s[i] = s_axis_tdata[S_AXIS_TDATA_WIDTH - MISC_WIDTH + i];
        end
    end

    // Register the tap word once per handshake
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            misc_data_r <= '0;
        end else if (hs_s) begin
            misc_data_r <= misc_next_s;
        end
    end

    axis_pulse_meta_uart_tx #(
        .DATA_WIDTH     (CNT_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_uart_tx (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (uart_load_s),
        .data     (pulse_count_r),
        .hs       (hs_s),
        .prescale (cfg_prescale),
        .line     (uart_line_s),
        .busy     (uart_busy_s)
    );

    assign misc_data    = misc_data_r;
    assign pulse_count  = pulse_count_r;
    assign uart_overrun = uart_overrun_r;

endmodule

// File: tb/tb_axis_pulse_meta_reader.sv
// Directed bench for axis_pulse_meta_reader: a vector table for the tap,
// edge and reflect behaviour, then hand-written UART frame sequences.
module tb_axis_pulse_meta_reader;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  cfg_prescale;
    logic        cfg_truncate;
    logic [7:0]  misc_data;
    logic [39:0] pulse_count;
    logic        uart_overrun;
    logic        s_axis_tready;
    logic [39:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;

    always #5 aclk = ~aclk;

    axis_pulse_meta_reader dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_prescale  (cfg_prescale),
        .cfg_truncate  (cfg_truncate),
        .misc_data     (misc_data),
        .pulse_count   (pulse_count),
        .uart_overrun  (uart_overrun),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid)
    );

    typedef struct {
        logic [39:0] tdata;
        logic        tready;
        logic [7:0]  exp_misc;
        logic [39:0] exp_cnt;
    } vec_t;

    vec_t vecs [13];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference UART bit: start 0, 7 data bits, flag (byte 0 only), stop 1, pad 1
    function automatic logic frame_bit(input logic [39:0] c, input int i);
        int          byte_i;
        int          b;
        logic [47:0] padded;
        byte_i = i / 11;
        b      = i % 11;
        padded = {8'h00, c};
        if (b == 0) return 1'b0;
        if (b <= 7) return padded[byte_i*7 + b - 1];
        if (b == 8) return (byte_i == 0);
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic hs_step(input logic key);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {key, 7'h00, 32'hCAFE_0000};
        tick();
    endtask

    task automatic pulse();
        hs_step(1'b0);
        hs_step(1'b1);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        logic [39:0]  refl;
        int           act_n;
        int           errs;
        logic [200:0] line_v;
        logic [10:0]  b0;
        logic [7:0]   hold;
        logic         key;

        vecs[0]  = '{40'h10_1234_5678, 1'b1, 8'h11, 40'd0};
        vecs[1]  = '{40'h80_0000_0002, 1'b1, 8'h89, 40'd1};
        vecs[2]  = '{40'hC0_2222_2222, 1'b1, 8'hC4, 40'd1};
        vecs[3]  = '{40'h70_3333_3333, 1'b1, 8'h74, 40'd1};
        vecs[4]  = '{40'hF0_4444_4444, 1'b1, 8'hFC, 40'd2};
        vecs[5]  = '{40'h90_5555_5555, 1'b1, 8'h96, 40'd2};
        vecs[6]  = '{40'h00_6666_6666, 1'b1, 8'h04, 40'd2};
        vecs[7]  = '{40'hA0_7777_7777, 1'b1, 8'hAC, 40'd3};
        vecs[8]  = '{40'h30_8888_8888, 1'b1, 8'h34, 40'd3};
        vecs[9]  = '{40'h00_9999_9999, 1'b1, 8'h06, 40'd3};
        vecs[10] = '{40'h00_AAAA_AAAA, 1'b1, 8'h05, 40'd3};
        vecs[11] = '{40'hF0_BBBB_BBBB, 1'b0, 8'h05, 40'd3};
        vecs[12] = '{40'h50_CCCC_CCCC, 1'b1, 8'h55, 40'd3};

        aresetn       = 1'b0;
        cfg_prescale  = 8'd0;
        cfg_truncate  = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 40'h80_0000_0000;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_misc", 64'(misc_data), 64'd0);
        check("rst_count", 64'(pulse_count), 64'd0);
        check("rst_overrun", 64'(uart_overrun), 64'd0);
        aresetn = 1'b1;
        s_axis_tdata = 40'h00_0000_0000;
        tick();
        check("enbl_tready", 64'(s_axis_tready), 64'd1);
        check("enbl_tvalid", 64'(m_axis_tvalid), 64'd1);

        // Tap / edge / reflect vectors
        for (int i = 0; i < 13; i++) begin
            m_axis_tready = vecs[i].tready;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = vecs[i].tdata;
            #1;
            check($sformatf("vec%0d_mdata", i), 64'(m_axis_tdata), 64'(vecs[i].tdata[31:0]));
            check($sformatf("vec%0d_sready", i), 64'(s_axis_tready), 64'(vecs[i].tready));
            @(posedge aclk);
            #1;
            check($sformatf("vec%0d_misc", i), 64'(misc_data), 64'(vecs[i].exp_misc));
            check($sformatf("vec%0d_count", i), 64'(pulse_count), 64'(vecs[i].exp_cnt));
        end
        m_axis_tready = 1'b1;

        // Reset in the middle of the count-0 frame
        aresetn = 1'b0;
        tick();
        check("midrst_count", 64'(pulse_count), 64'd0);
        check("midrst_misc", 64'(misc_data), 64'd0);
        aresetn = 1'b1;
        tick();
        hs_step(1'b0);
        check("midrst_line", 64'(misc_data[0]), 64'd1);
        check("midrst_refl_active", 64'(misc_data[2]), 64'd0);

        // Reflect of count 5
        repeat (6) pulse();
        check("refl_count", 64'(pulse_count), 64'd6);
        refl  = '0;
        act_n = 0;
        for (int j = 0; j < 40; j++) begin
            hs_step(1'b0);
            refl[j] = misc_data[1];
            if (misc_data[2]) act_n++;
        end
        check("refl_bits", 64'(refl), 64'd5);
        check("refl_active_len", 64'(act_n), 64'd39);
        repeat (30) hs_step(1'b0);
        check("idle_line", 64'(misc_data[0]), 64'd1);
        check("no_overrun_a", 64'(uart_overrun), 64'd0);

        // Prescale 2 frame at count 0x10, with prescale change and a stall mid-frame
        repeat (10) pulse();
        check("pre16_count", 64'(pulse_count), 64'd16);
        cfg_prescale = 8'd2;
        pulse();
        line_v = '0;
        for (int j = 1; j <= 200; j++) begin
            if (j == 50) cfg_prescale = 8'd5;
            if (j == 100) begin
                hold = misc_data;
                m_axis_tready = 1'b0;
                repeat (10) tick();
                check("stall_misc", 64'(misc_data), 64'(hold));
                check("stall_count", 64'(pulse_count), 64'd17);
                m_axis_tready = 1'b1;
            end
            hs_step(1'b0);
            line_v[j] = misc_data[0];
        end
        errs = 0;
        for (int j = 1; j <= 200; j++) begin
            if (line_v[j] !== ((j <= 198) ? frame_bit(40'h10, (j - 1) / 3) : 1'b1)) errs++;
        end
        check("frame16_p2_errs", 64'(errs), 64'd0);
        for (int k = 0; k < 11; k++) b0[k] = line_v[1 + 3*k];
        check("frame16_byte0", 64'(b0), 64'h720);
        cfg_prescale = 8'd0;
        check("no_overrun_b", 64'(uart_overrun), 64'd0);

        // Drop policy: start at 48 while count-32 frame is busy
        repeat (15) pulse();
        pulse();
        check("pre_drop_count", 64'(pulse_count), 64'd33);
        line_v = '0;
        for (int j = 1; j <= 70; j++) begin
            key = (j <= 32) ? ((j % 2) == 0) : 1'b0;
            hs_step(key);
            line_v[j] = misc_data[0];
        end
        errs = 0;
        for (int j = 1; j <= 70; j++) begin
            if (line_v[j] !== ((j <= 66) ? frame_bit(40'd32, j - 1) : 1'b1)) errs++;
        end
        check("drop_frame_errs", 64'(errs), 64'd0);
        check("drop_overrun", 64'(uart_overrun), 64'd1);
        check("drop_count", 64'(pulse_count), 64'd49);

        // Truncate policy: start at 16 restarts the count-0 frame
        do_reset();
        check("trunc_rst_overrun", 64'(uart_overrun), 64'd0);
        cfg_truncate = 1'b1;
        pulse();
        repeat (15) pulse();
        check("trunc_pre_overrun", 64'(uart_overrun), 64'd0);
        pulse();
        line_v = '0;
        for (int j = 1; j <= 70; j++) begin
            hs_step(1'b0);
            line_v[j] = misc_data[0];
        end
        errs = 0;
        for (int j = 1; j <= 70; j++) begin
            if (line_v[j] !== ((j <= 66) ? frame_bit(40'd16, j - 1) : 1'b1)) errs++;
        end
        check("trunc_frame_errs", 64'(errs), 64'd0);
        check("trunc_overrun", 64'(uart_overrun), 64'd1);
        check("trunc_count", 64'(pulse_count), 64'd17);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
